// File: rtl/ysyx_23060059_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-master AXI4 arbiter.
// Reads are serialised on one AR/R pair; LSU writes pass through one at a time.
module ysyx_23060059_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  input  logic [3:0]          ifu_arid,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic                ifu_arready,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic [3:0]          ifu_rid,
  output logic                ifu_rvalid,
  output logic                ifu_rlast,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  input  logic [3:0]          lsu_arid,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  output logic                lsu_arready,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic [3:0]          lsu_rid,
  output logic                lsu_rvalid,
  output logic                lsu_rlast,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [3:0]          lsu_awid,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic                lsu_bready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  input  logic [1:0]          rresp,
  input  logic [3:0]          rid,
  input  logic                rlast,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  output logic                wlast,
  output logic                bready,
  input  logic                awready,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp
);

  typedef enum logic [1:0] {R_IDLE, R_IFU, R_LSU} rstate_t;
  typedef enum logic {W_IDLE, W_BUSY} wstate_t;
  typedef enum logic {GRANT_IFU, GRANT_LSU} grant_t;

  rstate_t rstate;
  wstate_t wstate;
  grant_t  last_grant;
  logic    ar_done;

  // Grant is registered; the burst is released only by the rlast handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate     <= R_IDLE;
      last_grant <= GRANT_IFU;
      ar_done    <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          ar_done <= 1'b0;
          if (lsu_arvalid && (!ifu_arvalid || last_grant == GRANT_IFU)) begin
            rstate     <= R_LSU;
            last_grant <= GRANT_LSU;
          end else if (ifu_arvalid) begin
            rstate     <= R_IFU;
            last_grant <= GRANT_IFU;
          end
        end
        R_IFU, R_LSU: begin
          if (arvalid && arready) ar_done <= 1'b1;
          if (rvalid && rready && rlast) begin
            rstate  <= R_IDLE;
            ar_done <= 1'b0;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate <= W_IDLE;
    end else begin
      case (wstate)
        W_IDLE:  if (lsu_awvalid) wstate <= W_BUSY;
        W_BUSY:  if (bvalid && bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    araddr      = '0;
    arvalid     = 1'b0;
    arid        = '0;
    arlen       = '0;
    arsize      = '0;
    arburst     = '0;
    rready      = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rid     = '0;
    ifu_rvalid  = 1'b0;
    ifu_rlast   = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rid     = '0;
    lsu_rvalid  = 1'b0;
    lsu_rlast   = 1'b0;
    case (rstate)
      R_IFU: begin
        araddr      = ifu_araddr;
        arvalid     = ifu_arvalid && !ar_done;
        arid        = ifu_arid;
        arlen       = ifu_arlen;
        arsize      = ifu_arsize;
        arburst     = ifu_arburst;
        rready      = ifu_rready;
        ifu_arready = arready && !ar_done;
        ifu_rdata   = rdata;
        ifu_rresp   = rresp;
        ifu_rid     = rid;
        ifu_rvalid  = rvalid;
        ifu_rlast   = rlast;
      end
      R_LSU: begin
        araddr      = lsu_araddr;
        arvalid     = lsu_arvalid && !ar_done;
        arid        = lsu_arid;
        arlen       = lsu_arlen;
        arsize      = lsu_arsize;
        arburst     = lsu_arburst;
        rready      = lsu_rready;
        lsu_arready = arready && !ar_done;
        lsu_rdata   = rdata;
        lsu_rresp   = rresp;
        lsu_rid     = rid;
        lsu_rvalid  = rvalid;
        lsu_rlast   = rlast;
      end
      default: ;
    endcase
  end

  always_comb begin
    awaddr      = '0;
    awvalid     = 1'b0;
    awid        = '0;
    awlen       = '0;
    awsize      = '0;
    awburst     = '0;
    wdata       = '0;
    wstrb       = '0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    if (wstate == W_BUSY) begin
      awaddr      = lsu_awaddr;
      awvalid     = lsu_awvalid;
      awid        = lsu_awid;
      awlen       = lsu_awlen;
      awsize      = lsu_awsize;
      awburst     = lsu_awburst;
      wdata       = lsu_wdata;
      wstrb       = lsu_wstrb;
      wvalid      = lsu_wvalid;
      wlast       = lsu_wlast;
      bready      = lsu_bready;
      lsu_awready = awready;
      lsu_wready  = wready;
      lsu_bvalid  = bvalid;
      lsu_bresp   = bresp;
    end
  end

endmodule
